axi_slave_mem: RTL and testbench

Parametrised AXI slave memory model; next generation of the generic slave paired with axi_master_bfm in block-level benches.
- Byte-addressable RAM of MEM_DEPTH words; FIXED/INCR/WRAP bursts; per-byte strobes; OKAY/SLVERR/DECERR responses.
- Independent write and read engines; sustains one beat per cycle.

---
 rtl/axi_bfm_pkg.sv | 34 +++
 rtl/axi_burst_addr_gen.sv | 35 +++
 rtl/axi_slave_mem.sv | 239 +++++++++++++++++++++++
 tb/tb_axi_slave_mem.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_bfm_pkg.sv
// Shared encodings for the AXI slave memory: burst types, responses and FSM states,
// plus the WRAP length legality rule used by the burst address generators.
package axi_bfm_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'b00,
    W_DATA = 2'b01,
    W_RESP = 2'b10
  } wstate_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rstate_e;

  function automatic logic wrap_len_ok(input logic [3:0] len);
    return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Next word index for FIXED/INCR/WRAP bursts and burst legality (reserved type,
// illegal WRAP length). Purely combinational; one instance per channel.
module axi_burst_addr_gen
  import axi_bfm_pkg::*;
#(
  parameter int IDX_W = 10
) (
  input  logic [IDX_W-1:0] cur_idx,
  input  logic [3:0]       len,
  input  logic [1:0]       burst,
  output logic [IDX_W-1:0] next_idx,
  output logic             legal
);

  logic [IDX_W-1:0] wrap_mask;
  logic [IDX_W-1:0] incr_idx;

  always_comb begin
    wrap_mask = IDX_W'(len);
    incr_idx  = cur_idx + IDX_W'(1);
    next_idx  = cur_idx;
    legal     = 1'b1;
    case (burst)
      BURST_FIXED: next_idx = cur_idx;
      BURST_INCR:  next_idx = incr_idx;
      BURST_WRAP: begin
        // Only the low bits inside the (len+1)-word window advance
        next_idx = (cur_idx & ~wrap_mask) | (incr_idx & wrap_mask);
        legal    = wrap_len_ok(len);
      end
      default:     legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/axi_slave_mem.sv
// AXI slave RAM model with independent write/read engines, one beat per cycle.
// Optional `AXI_SLAVE_MEM_BACKPRESSURE_EN: LFSR-driven stalls on wready and new rvalid.
module axi_slave_mem
  import axi_bfm_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awadr,
  input  logic [3:0]              awlen,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wrdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ID_WIDTH-1:0]     arid,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [3:0]              arlen,
  input  logic [1:0]              arburst,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [ID_WIDTH-1:0]     rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int STRB_W  = DATA_WIDTH / 8;
  localparam int BYTE_W  = $clog2(STRB_W);
  localparam int IDX_W   = $clog2(MEM_DEPTH);
  localparam int TOP_LSB = IDX_W + BYTE_W;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic                  run_q, run_d;
  wstate_e               w_state_q, w_state_d;
  logic [ID_WIDTH-1:0]   w_id_q, w_id_d;
  logic [IDX_W-1:0]      w_idx_q, w_idx_d;
  logic [3:0]            w_len_q, w_len_d, w_beat_q, w_beat_d;
  logic [1:0]            w_burst_q, w_burst_d, bresp_q, bresp_d;
  logic                  w_err_q, w_err_d;
  logic                  mem_we;
  rstate_e               r_state_q, r_state_d;
  logic [ID_WIDTH-1:0]   r_id_q, r_id_d;
  logic [IDX_W-1:0]      r_idx_q, r_idx_d;
  logic [3:0]            r_len_q, r_len_d, r_beat_q, r_beat_d;
  logic [1:0]            r_burst_q, r_burst_d, r_resp_q, r_resp_d;
  logic                  rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [IDX_W-1:0]      w_next_idx, r_next_idx;
  logic                  w_legal, r_legal, r_issue, stall;

`ifdef AXI_SLAVE_MEM_BACKPRESSURE_EN
  logic [15:0] lfsr_q, lfsr_d;
  always_comb lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) lfsr_q <= 16'hACE1;
    else          lfsr_q <= lfsr_d;
  end
  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // In IDLE the generators see the incoming request so legality is known at handshake
  axi_burst_addr_gen #(.IDX_W(IDX_W)) u_wgen (
    .cur_idx  (w_idx_q),
    .len      ((w_state_q == W_IDLE) ? awlen : w_len_q),
    .burst    ((w_state_q == W_IDLE) ? awburst : w_burst_q),
    .next_idx (w_next_idx),
    .legal    (w_legal)
  );

  axi_burst_addr_gen #(.IDX_W(IDX_W)) u_rgen (
    .cur_idx  (r_idx_q),
    .len      ((r_state_q == R_IDLE) ? arlen : r_len_q),
    .burst    ((r_state_q == R_IDLE) ? arburst : r_burst_q),
    .next_idx (r_next_idx),
    .legal    (r_legal)
  );

  assign awready = run_q && (w_state_q == W_IDLE);
  assign wready  = (w_state_q == W_DATA) && !stall;
  assign bvalid  = (w_state_q == W_RESP);
  assign bid     = w_id_q;
  assign bresp   = bresp_q;
  assign arready = run_q && (r_state_q == R_IDLE);
  assign rvalid  = rvalid_q;
  assign rlast   = rlast_q;
  assign rdata   = rdata_q;
  assign rresp   = r_resp_q;
  assign rid     = r_id_q;

  always_comb begin
    run_d     = 1'b1;
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    w_idx_d   = w_idx_q;
    w_len_d   = w_len_q;
    w_beat_d  = w_beat_q;
    w_burst_d = w_burst_q;
    w_err_d   = w_err_q;
    bresp_d   = bresp_q;
    mem_we    = 1'b0;
    case (w_state_q)
      W_IDLE: if (awvalid && awready) begin
        w_id_d    = awid;
        w_idx_d   = IDX_W'(awadr >> BYTE_W);
        w_len_d   = awlen;
        w_burst_d = awburst;
        w_beat_d  = '0;
        if ((awadr >> TOP_LSB) != '0) bresp_d = RESP_DECERR;
        else if (!w_legal)            bresp_d = RESP_SLVERR;
        else                          bresp_d = RESP_OKAY;
        w_err_d   = (bresp_d != RESP_OKAY);
        w_state_d = W_DATA;
      end
      W_DATA: if (wvalid && wready) begin
        mem_we   = !w_err_q;
        w_idx_d  = w_next_idx;
        w_beat_d = w_beat_q + 4'd1;
        if ((wlast != (w_beat_q == w_len_q)) && (bresp_q == RESP_OKAY)) bresp_d = RESP_SLVERR;
        if (w_beat_q == w_len_q) w_state_d = W_RESP;
      end
      W_RESP: if (bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  // The output register only reloads when empty or being consumed, so R stays stable under backpressure
  assign r_issue = (r_state_q == R_DATA) && !(rvalid_q && rlast_q) && (!rvalid_q || rready) && !stall;

  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_idx_d   = r_idx_q;
    r_len_d   = r_len_q;
    r_beat_d  = r_beat_q;
    r_burst_d = r_burst_q;
    r_resp_d  = r_resp_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rdata_d   = rdata_q;
    case (r_state_q)
      R_IDLE: if (arvalid && arready) begin
        r_id_d    = arid;
        r_idx_d   = IDX_W'(araddr >> BYTE_W);
        r_len_d   = arlen;
        r_burst_d = arburst;
        r_beat_d  = '0;
        if ((araddr >> TOP_LSB) != '0) r_resp_d = RESP_DECERR;
        else if (!r_legal)             r_resp_d = RESP_SLVERR;
        else                           r_resp_d = RESP_OKAY;
        r_state_d = R_DATA;
      end
      R_DATA: begin
        if (r_issue) begin
          rvalid_d = 1'b1;
          rlast_d  = (r_beat_q == r_len_q);
          rdata_d  = (r_resp_q == RESP_OKAY) ? mem[r_idx_q] : '0;
          r_idx_d  = r_next_idx;
          r_beat_d = r_beat_q + 4'd1;
        end else if (rvalid_q && rready) begin
          rvalid_d = 1'b0;
          rlast_d  = 1'b0;
        end
        if (rvalid_q && rready && rlast_q) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      run_q     <= 1'b0;
      w_state_q <= W_IDLE;
      w_id_q    <= '0;
      w_idx_q   <= '0;
      w_len_q   <= '0;
      w_beat_q  <= '0;
      w_burst_q <= '0;
      w_err_q   <= 1'b0;
      bresp_q   <= '0;
      r_state_q <= R_IDLE;
      r_id_q    <= '0;
      r_idx_q   <= '0;
      r_len_q   <= '0;
      r_beat_q  <= '0;
      r_burst_q <= '0;
      r_resp_q  <= '0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      run_q     <= run_d;
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
      w_idx_q   <= w_idx_d;
      w_len_q   <= w_len_d;
      w_beat_q  <= w_beat_d;
      w_burst_q <= w_burst_d;
      w_err_q   <= w_err_d;
      bresp_q   <= bresp_d;
      r_state_q <= r_state_d;
      r_id_q    <= r_id_d;
      r_idx_q   <= r_idx_d;
      r_len_q   <= r_len_d;
      r_beat_q  <= r_beat_d;
      r_burst_q <= r_burst_d;
      r_resp_q  <= r_resp_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rdata_q   <= rdata_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < STRB_W; i++) begin
        if (wstrb[i]) mem[w_idx_q][8*i +: 8] <= wrdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed bench for axi_slave_mem: reset, single/INCR/WRAP/FIXED bursts, strobes,
// error responses, R-channel backpressure and reset in the middle of a burst.
module tb_axi_slave_mem;
  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [3:0]  awid = '0, bid, arid = '0, rid;
  logic [31:0] awadr = '0, araddr = '0, wrdata = '0, rdata;
  logic [3:0]  awlen = '0, arlen = '0, wstrb = '0;
  logic [1:0]  awburst = '0, arburst = '0, bresp, rresp;
  logic        awvalid = 0, awready, wlast = 0, wvalid = 0, wready, bvalid, bready = 0;
  logic        arvalid = 0, arready, rlast, rvalid, rready = 0;

  always #5 aclk = ~aclk;

  axi_slave_mem #(.DATA_WIDTH(32), .ID_WIDTH(4), .ADDR_WIDTH(32), .MEM_DEPTH(1024)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awid(awid), .awadr(awadr), .awlen(awlen), .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wrdata(wrdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  int total = 0;
  int bad = 0;
  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  logic [31:0] rd [16];
  logic [1:0]  rr [16];
  logic        rl [16];
  logic [3:0]  rdid [16];
  int          rcyc [16];
  int          nb, lat, b_wait;
  logic [1:0]  b_resp;
  logic [3:0]  b_id;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_write(input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst,
                          input logic [3:0] id, input int last_at);
    int n;
    awid = id; awadr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin @(negedge aclk); n++; end
    if (n >= 50) begin total++; bad++; $display("FAIL aw_timeout: awready=%b required 1", awready); end
    @(posedge aclk); #1 awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wrdata = wd[i]; wstrb = ws[i]; wvalid = 1'b1;
      wlast = (last_at < 0) ? (i == int'(len)) : (i == last_at);
      n = 0;
      while (!wready && n < 50) begin @(negedge aclk); n++; end
      if (n >= 50) begin total++; bad++; $display("FAIL w_timeout: beat %0d wready=%b required 1", i, wready); end
      @(posedge aclk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    b_wait = 0;
    while (!bvalid && b_wait < 50) begin @(negedge aclk); b_wait++; end
    if (b_wait >= 50) begin total++; bad++; $display("FAIL b_timeout: bvalid=%b required 1", bvalid); end
    b_resp = bresp; b_id = bid;
    @(posedge aclk); #1 bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst,
                         input logic [3:0] id);
    int n;
    arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    while (!arready && n < 50) begin @(negedge aclk); n++; end
    if (n >= 50) begin total++; bad++; $display("FAIL ar_timeout: arready=%b required 1", arready); end
    @(posedge aclk); #1 arvalid = 1'b0;
    lat = 0; nb = 0; n = 0;
    while (nb <= int'(len) && n < 100) begin
      @(negedge aclk); n++;
      if (rvalid) begin
        if (nb == 0) lat = n;
        rd[nb] = rdata; rr[nb] = rresp; rl[nb] = rlast; rdid[nb] = rid; rcyc[nb] = n; nb++;
      end
    end
    if (nb <= int'(len)) begin total++; bad++; $display("FAIL r_timeout: beats=%0d required %0d", nb, int'(len) + 1); end
    @(posedge aclk); #1 rready = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge aclk);
    total++;
    if ({awready, arready, wready, bvalid, rvalid, rlast, bresp, rresp, rdata, bid, rid} !== '0)
      begin bad++; $display("FAIL reset_outputs: aw=%b ar=%b w=%b b=%b r=%b rdata=%h required all 0",
                            awready, arready, wready, bvalid, rvalid, rdata); end
    aresetn = 1'b1;
    #1 total++;
    if (awready !== 1'b0) begin bad++; $display("FAIL ready_before_edge: awready=%b required 0", awready); end
    @(negedge aclk);
    total++;
    if (awready !== 1'b1 || arready !== 1'b1)
      begin bad++; $display("FAIL ready_after_edge: awready=%b arready=%b required 1 1", awready, arready); end
  endtask

  task automatic test_single;
    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    do_write(32'h10, 4'd0, 2'b01, 4'h5, -1);
    total++;
    if (b_resp !== 2'b00 || b_id !== 4'h5 || b_wait !== 0)
      begin bad++; $display("FAIL single_b: bresp=%b bid=%h wait=%0d required 00 5 0", b_resp, b_id, b_wait); end
    do_read(32'h10, 4'd0, 2'b01, 4'h9);
    total++;
    if (rd[0] !== 32'hDEADBEEF || rr[0] !== 2'b00 || rl[0] !== 1'b1 || rdid[0] !== 4'h9)
      begin bad++; $display("FAIL single_r: rdata=%h rresp=%b rlast=%b rid=%h required deadbeef 00 1 9",
                            rd[0], rr[0], rl[0], rdid[0]); end
    total++;
    if (lat !== 2) begin bad++; $display("FAIL read_latency: %0d required 2", lat); end
  endtask

  task automatic test_incr;
    for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
    do_write(32'h100, 4'd3, 2'b01, 4'h1, -1);
    total++;
    if (b_resp !== 2'b00) begin bad++; $display("FAIL incr_b: bresp=%b required 00", b_resp); end
    do_read(32'h100, 4'd3, 2'b01, 4'h2);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (rd[i] !== 32'(i + 1) || rl[i] !== (i == 3) || rcyc[i] !== lat + i || rr[i] !== 2'b00)
        begin bad++; $display("FAIL incr_r%0d: rdata=%h rlast=%b cyc=%0d required %h %b %0d",
                              i, rd[i], rl[i], rcyc[i], 32'(i + 1), (i == 3), lat + i); end
    end
  endtask

  task automatic test_wrap;
    logic [31:0] exp [4];
    exp[0] = 32'd3; exp[1] = 32'd4; exp[2] = 32'd1; exp[3] = 32'd2;
    for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
    do_write(32'h108, 4'd3, 2'b10, 4'h3, -1);
    total++;
    if (b_resp !== 2'b00) begin bad++; $display("FAIL wrap_b: bresp=%b required 00", b_resp); end
    do_read(32'h100, 4'd3, 2'b01, 4'h3);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (rd[i] !== exp[i]) begin bad++; $display("FAIL wrap_r%0d: rdata=%h required %h", i, rd[i], exp[i]); end
    end
    do_read(32'h108, 4'd3, 2'b10, 4'h3);
    total++;
    if (rd[0] !== 32'd1 || rd[1] !== 32'd2 || rd[2] !== 32'd3 || rd[3] !== 32'd4)
      begin bad++; $display("FAIL wrap_read: %h %h %h %h required 1 2 3 4", rd[0], rd[1], rd[2], rd[3]); end
    for (int i = 0; i < 3; i++) begin wd[i] = 32'h99; ws[i] = 4'hF; end
    do_write(32'h100, 4'd2, 2'b10, 4'h3, -1);
    total++;
    if (b_resp !== 2'b10) begin bad++; $display("FAIL wrap_len2_b: bresp=%b required 10", b_resp); end
    do_read(32'h100, 4'd3, 2'b01, 4'h3);
    total++;
    if (rd[0] !== 32'd3 || rd[1] !== 32'd4 || rd[2] !== 32'd1)
      begin bad++; $display("FAIL wrap_len2_mem: %h %h %h required 3 4 1", rd[0], rd[1], rd[2]); end
  endtask

  task automatic test_fixed;
    wd[0] = 32'hA; wd[1] = 32'hB; ws[0] = 4'hF; ws[1] = 4'hF;
    do_write(32'h200, 4'd1, 2'b00, 4'h4, -1);
    do_read(32'h200, 4'd1, 2'b00, 4'h4);
    total++;
    if (rd[0] !== 32'hB || rd[1] !== 32'hB || rl[1] !== 1'b1)
      begin bad++; $display("FAIL fixed_r: %h %h last=%b required b b 1", rd[0], rd[1], rl[1]); end
  endtask

  task automatic test_strobe;
    wd[0] = 32'h11223344; ws[0] = 4'hF;
    do_write(32'h20, 4'd0, 2'b01, 4'h6, -1);
    wd[0] = 32'hAABBCCDD; ws[0] = 4'b0101;
    do_write(32'h20, 4'd0, 2'b01, 4'h6, -1);
    do_read(32'h20, 4'd0, 2'b01, 4'h6);
    total++;
    if (rd[0] !== 32'h11BB33DD) begin bad++; $display("FAIL strobe: rdata=%h required 11bb33dd", rd[0]); end
    for (int i = 0; i < 4; i++) begin wd[i] = 32'(i); ws[i] = 4'hF; end
    do_write(32'h300, 4'd3, 2'b01, 4'h7, 1);
    total++;
    if (b_resp !== 2'b10 || b_id !== 4'h7)
      begin bad++; $display("FAIL early_wlast: bresp=%b bid=%h required 10 7", b_resp, b_id); end
  endtask

  task automatic test_decerr;
    wd[0] = 32'h55; ws[0] = 4'hF;
    do_write(32'h0, 4'd0, 2'b01, 4'h0, -1);
    wd[0] = 32'hFFFFFFFF;
    do_write(32'h8000_0000, 4'd0, 2'b01, 4'hA, -1);
    total++;
    if (b_resp !== 2'b11) begin bad++; $display("FAIL decerr_b: bresp=%b required 11", b_resp); end
    do_read(32'h8000_0000, 4'd0, 2'b01, 4'hB);
    total++;
    if (rr[0] !== 2'b11 || rd[0] !== 32'h0 || rl[0] !== 1'b1 || rdid[0] !== 4'hB)
      begin bad++; $display("FAIL decerr_r: rresp=%b rdata=%h rlast=%b required 11 0 1", rr[0], rd[0], rl[0]); end
    do_read(32'h0, 4'd0, 2'b01, 4'h0);
    total++;
    if (rd[0] !== 32'h55) begin bad++; $display("FAIL decerr_nowrite: mem[0]=%h required 55", rd[0]); end
  endtask

  task automatic test_rready_stall;
    logic [31:0] exp [4];
    logic [31:0] snap_d;
    logic        snap_l;
    int got, held, n;
    exp[0] = 32'd3; exp[1] = 32'd4; exp[2] = 32'd1; exp[3] = 32'd2;
    arid = 4'hC; araddr = 32'h100; arlen = 4'd3; arburst = 2'b01; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin @(negedge aclk); n++; end
    @(posedge aclk); #1 arvalid = 1'b0;
    got = 0; held = 0; n = 0;
    while (got < 4 && n < 100) begin
      @(negedge aclk); n++;
      if (got == 2 && held < 5) begin
        rready = 1'b0;
        if (held == 0) begin snap_d = rdata; snap_l = rlast; end
        else begin
          total++;
          if (rvalid !== 1'b1 || rdata !== snap_d || rlast !== snap_l || rid !== 4'hC || rresp !== 2'b00)
            begin bad++; $display("FAIL stall_hold%0d: rvalid=%b rdata=%h rlast=%b required 1 %h %b",
                                  held, rvalid, rdata, rlast, snap_d, snap_l); end
        end
        held++;
      end else begin
        rready = 1'b1;
        if (rvalid) begin rd[got] = rdata; rl[got] = rlast; got++; end
      end
    end
    @(posedge aclk); #1 rready = 1'b0;
    total++;
    if (got != 4) begin bad++; $display("FAIL stall_beats: got=%0d required 4", got); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (rd[i] !== exp[i] || rl[i] !== (i == 3))
        begin bad++; $display("FAIL stall_r%0d: rdata=%h rlast=%b required %h %b", i, rd[i], rl[i], exp[i], (i == 3)); end
    end
  endtask

  task automatic test_reset_mid;
    int n;
    awid = 4'hD; awadr = 32'h400; awlen = 4'd7; awburst = 2'b01; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin @(negedge aclk); n++; end
    @(posedge aclk); #1 awvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wrdata = 32'h10 + 32'(i); wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
      n = 0;
      while (!wready && n < 50) begin @(negedge aclk); n++; end
      if (i < 2) begin @(posedge aclk); #1; end
    end
    aresetn = 1'b0;
    #1 total++;
    if ({awready, arready, wready, bvalid, rvalid, bresp, bid} !== '0)
      begin bad++; $display("FAIL midreset_outputs: aw=%b ar=%b w=%b b=%b r=%b required all 0",
                            awready, arready, wready, bvalid, rvalid); end
    wvalid = 1'b0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    total++;
    if (awready !== 1'b1) begin bad++; $display("FAIL midreset_awready: %b required 1", awready); end
    do_read(32'h400, 4'd1, 2'b01, 4'hE);
    total++;
    if (rd[0] !== 32'h10 || rd[1] !== 32'h11)
      begin bad++; $display("FAIL midreset_mem: %h %h required 10 11", rd[0], rd[1]); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_incr();
    test_wrap();
    test_fixed();
    test_strobe();
    test_decerr();
    test_rready_stall();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
